// File: rtl/psi_payload_tx_pkg.sv
// psi_payload_pkg: shared constants and FSM state types for the PSI payload transmitter
//  TS_SYNC_BYTE : first byte of every valid TS packet
//  TS_PKT_BYTES : bytes per TS packet
//  FRAME_WORDS  : header word plus 47 packed data words
//  NULL_PID     : PID of stuffing packets
package psi_payload_pkg;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int TS_PKT_BYTES = 188;
  localparam int FRAME_WORDS = 48;
  localparam logic [12:0] NULL_PID = 13'h1FFF;
  typedef enum logic {W_IDLE, W_PKT} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA} r_state_t;
endpackage

// File: rtl/psi_payload_tx_if.sv
// psi_payload_tx_if: 32-bit frame bus from the payload transmitter to the PSI filter receiver
//  payload_out_ready : receiver idle, a frame may start
//  payload_out_valid : word qualifier
//  payload_out_start : header word marker
//  payload_out_end   : last word marker
//  payload_out_data  : frame word
interface psi_payload_tx_if;
  logic payload_out_ready;
  logic payload_out_valid;
  logic payload_out_start;
  logic payload_out_end;
  logic [31:0] payload_out_data;
  modport master (
    input  payload_out_ready,
    output payload_out_valid, payload_out_start, payload_out_end, payload_out_data
  );
  modport slave (
    output payload_out_ready,
    input  payload_out_valid, payload_out_start, payload_out_end, payload_out_data
  );
endinterface

// File: rtl/psi_tx_word_fifo.sv
// psi_tx_word_fifo: simple-dual-port word buffer with write, commit and read pointers
//  clk/rst    : clock, async active-high reset
//  we/wdata   : word write at the write pointer (at the commit pointer when rolling back)
//  rollback   : write pointer returns to the commit pointer
//  commit     : commit pointer takes the current write pointer
//  re/roff    : registered read of word rd_ptr+roff into rdata
//  free_frame : read pointer advances one frame
//  level      : committed words not yet released
//  used       : all written words not yet released, including uncommitted ones
module psi_tx_word_fifo #(
  parameter int DEPTH = 128,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [31:0] wdata,
  input  logic rollback,
  input  logic commit,
  input  logic re,
  input  logic [5:0] roff,
  input  logic free_frame,
  output logic [31:0] rdata,
  output logic [LW-1:0] level,
  output logic [LW-1:0] used
);
  import psi_payload_pkg::*;
  localparam int AW = LW - 1;
  logic [31:0] mem [DEPTH];
  logic [LW-1:0] wr_ptr, cm_ptr, rd_ptr, wr_base, rd_addr;
  // rollback and a new header write may share a cycle: the header lands at the commit pointer
  assign wr_base = rollback ? cm_ptr : wr_ptr;
  assign rd_addr = rd_ptr + LW'(roff);
  assign level = cm_ptr - rd_ptr;
  assign used = wr_ptr - rd_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_base + LW'(we);
      if (commit) cm_ptr <= wr_ptr;
      if (free_frame) rd_ptr <= rd_ptr + LW'(FRAME_WORDS);
    end
  always_ff @(posedge clk) begin
    if (we) mem[wr_base[AW-1:0]] <= wdata;
    if (re) rdata <= mem[rd_addr[AW-1:0]];
  end
endmodule

// File: rtl/psi_payload_tx.sv
// psi_payload_tx: packs a byte-wide MPEG-TS stream into 48-word store-and-forward frames for the PSI filter receiver
//  payload_clk/payload_rst : clock, async active-high reset
//  ts_in_valid/sync/data/port : TS byte stream; port sampled on the sync byte
//  po         : frame bus, master side
//  fifo_level : committed words in the buffer
//  pkt_cnt    : frames sent (wraps)
//  drop_cnt   : packets dropped for error or overflow (saturates)
module psi_payload_tx #(
  parameter int FIFO_DEPTH = 128,
  parameter int PORT_WIDTH = 16,
  parameter bit DROP_NULL = 1'b1
) (
  input  logic payload_clk,
  input  logic payload_rst,
  input  logic ts_in_valid,
  input  logic ts_in_sync,
  input  logic [7:0] ts_in_data,
  input  logic [PORT_WIDTH-1:0] ts_in_port,
  psi_payload_tx_if.master po,
  output logic [7:0] fifo_level,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
);
  import psi_payload_pkg::*;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic [LW-1:0] level, used, free;
  logic [31:0] wdata, rdata;
  logic [23:0] sh, sh_n;
  logic [7:0] bcnt, bcnt_n;
  logic [1:0] drop_inc;
  logic [16:0] drop_sum;
  logic [5:0] ridx, ridx_n;
  logic sof, abort, start_ok, is_null, we, rollback, commit_set, commit_req;
  logic go, re, last_issue, s1_valid, s1_start, s1_end;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  assign sof = ts_in_valid & ts_in_sync;
  assign abort = sof && w_state == W_PKT;
  // an aborting sync sees the space freed by its own rollback
  assign free = LW'(FIFO_DEPTH) - (abort ? level : used);
  assign start_ok = ts_in_data == TS_SYNC_BYTE && free >= LW'(FRAME_WORDS);
  assign is_null = DROP_NULL && bcnt == 8'd2 && {sh[4:0], ts_in_data} == NULL_PID;
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
  assign fifo_level = 8'(level);
  always_comb begin
    w_next = w_state;
    we = 1'b0;
    wdata = {sh, ts_in_data};
    rollback = abort;
    commit_set = 1'b0;
    drop_inc = '0;
    sh_n = sh;
    bcnt_n = bcnt;
    if (sof) begin
      drop_inc = 2'(abort) + 2'(!start_ok);
      we = start_ok;
      wdata = 32'(ts_in_port);
      w_next = start_ok ? W_PKT : W_IDLE;
      sh_n = {16'h0, ts_in_data};
      bcnt_n = 8'd1;
    end else if (ts_in_valid && w_state == W_PKT) begin
      we = bcnt[1:0] == 2'd3;
      sh_n = {sh[15:0], ts_in_data};
      bcnt_n = bcnt + 8'd1;
      rollback = is_null;
      commit_set = bcnt == 8'(TS_PKT_BYTES - 1);
      w_next = (is_null || commit_set) ? W_IDLE : W_PKT;
    end
  end
  // commit lands one cycle after the last byte so it copies the pointer past the final word
  always_ff @(posedge payload_clk or posedge payload_rst)
    if (payload_rst) begin
      w_state <= W_IDLE;
      sh <= '0;
      bcnt <= '0;
      commit_req <= 1'b0;
      drop_cnt <= '0;
    end else begin
      w_state <= w_next;
      sh <= sh_n;
      bcnt <= bcnt_n;
      commit_req <= commit_set;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  // a pending commit counts as available so the header leaves three cycles after the last byte;
  // waiting for s1_valid to clear keeps the old frame from being re-read before its release
  assign go = r_state == R_IDLE && !s1_valid && po.payload_out_ready && (commit_req || level >= LW'(FRAME_WORDS));
  assign last_issue = r_state != R_IDLE && ridx == 6'(FRAME_WORDS - 1);
  assign re = go || r_state != R_IDLE;
  always_comb begin
    r_next = r_state == R_IDLE ? (go ? R_HDR : R_IDLE) : (last_issue ? R_IDLE : R_DATA);
    ridx_n = r_next == R_IDLE ? 6'd0 : ridx + 6'd1;
  end
  always_ff @(posedge payload_clk or posedge payload_rst)
    if (payload_rst) begin
      r_state <= R_IDLE;
      ridx <= '0;
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
      s1_end <= 1'b0;
      po.payload_out_valid <= 1'b0;
      po.payload_out_start <= 1'b0;
      po.payload_out_end <= 1'b0;
      po.payload_out_data <= '0;
      pkt_cnt <= '0;
    end else begin
      r_state <= r_next;
      ridx <= ridx_n;
      s1_valid <= re;
      s1_start <= go;
      s1_end <= last_issue;
      po.payload_out_valid <= s1_valid;
      po.payload_out_start <= s1_start;
      po.payload_out_end <= s1_end;
      po.payload_out_data <= s1_valid ? rdata : '0;
      pkt_cnt <= pkt_cnt + 16'(s1_end);
    end
  psi_tx_word_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk(payload_clk),
    .rst(payload_rst),
    .we(we),
    .wdata(wdata),
    .rollback(rollback),
    .commit(commit_req),
    .re(re),
    .roff(ridx),
    .free_frame(s1_end),
    .rdata(rdata),
    .level(level),
    .used(used)
  );
endmodule
